alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational `alu` block, with valid/ready handshakes on input and output.
- Single-cycle ops (add/sub/logic/shift/compare) return their result one cycle after accept.
- Multiply, divide and remainder run iteratively over WIDTH cycles.
- Adds status flags (zero, carry, overflow, err) and sits between operand fetch and writeback in the pipelined datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 4 and a power of two.
- OP_W, 5, opcode width; matches the existing ALUop field.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and op are presented
- in_ready  output  1  block accepts this cycle
- op  input  OP_W  operation select
- x  input  WIDTH  operand X
- y  input  WIDTH  operand Y
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer takes the result
- z  output  WIDTH  result
- flag_z  output  1  z == 0
- flag_c  output  1  carry out (ADD) / no-borrow (SUB)
- flag_v  output  1  signed overflow (ADD/SUB)
- flag_err  output  1  illegal op or divide by zero

Behaviour:
- Reset (async, any state): state = IDLE; z, all flags, out_valid = 0; internal counter and operand registers = 0. A reset during CALC abandons the op; nothing is emitted.
- FSM states: IDLE, CALC, DONE.
- Ready rule: in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept occurs on an edge where in_valid && in_ready; x, y, op are captured.
- Opcode map:
  - 00000 ADD
  - 00001 SUB (x−y)
  - 00010 AND
  - 00011 OR
  - 00100 XOR
  - 00101 NOT x
  - 00110 SHL by y[log2(WIDTH)-1:0]
  - 00111 SHR logical
  - 01000 SRA
  - 01001 SLT signed (z = 1 or 0)
  - 01010 MUL (low WIDTH bits, unsigned)
  - 01011 DIVU
  - 01100 REMU
  - any other code: z = 0, flag_err = 1, single-cycle.
- Single-cycle ops: on the accept edge, the result and flags are registered and state → DONE. out_valid = 1 the cycle after accept (latency 1).
- Multicycle ops (MUL/DIVU/REMU):
  - Accept edge: state → CALC, cnt = 0.
  - Each CALC edge performs one shift-add (MUL) or one restoring-divide step (DIVU/REMU), then cnt++.
  - The edge with cnt == WIDTH-1 writes z/flags and moves state → DONE.
  - out_valid rises exactly WIDTH cycles after accept. in_ready = 0 throughout CALC.
- Divide by zero (DIVU/REMU with y == 0): no iteration; result available with latency 1. DIVU gives z = all ones; REMU gives z = x. flag_err = 1 in both cases.
- DONE state:
  - z and flags are held stable while out_valid && !out_ready.
  - On out_ready: if a new accept also occurs that edge, proceed as a fresh accept (back-to-back, throughput 1 for single-cycle ops). Otherwise state → IDLE and out_valid = 0.
- Flag rules:
  - flag_c, flag_v meaningful only for ADD/SUB; 0 for all other ops.
  - SUB is computed as x + ~y + 1; flag_c is the carry out of that sum.
  - flag_v = signed overflow of the WIDTH-bit result.
  - flag_z is evaluated on z for every op, including err cases.
- Shifts: amount ≥ WIDTH is impossible by the masking above. SRA replicates x[WIDTH-1].
- z is never driven with partial iteration values; it only updates on completion.

Test Plan (WIDTH=16):
- ADD 0x7FFF+0x0001, out_ready=1 → out_valid one cycle after accept; z=0x8000, flag_v=1, flag_c=0, flag_z=0.
- SUB 0x0005−0x0005, then SLT x=0xFFFF y=0x0001 back-to-back with in_valid held → z=0x0000 (flag_z=1, flag_c=1), then z=0x0001; one result per cycle, in_ready never drops.
- MUL 0x0003×0x0005 → in_ready=0 for 16 cycles; out_valid exactly 16 cycles after accept; z=0x000F. Also 0x0100×0x0100 → z=0x0000, flag_z=1.
- DIVU 0x0064/0x0007 → z=0x000E after 16 cycles; REMU same operands → z=0x0002; DIVU 0x1234/0 → z=0xFFFF, flag_err=1, latency 1.
- Backpressure: ADD with out_ready=0 for 5 cycles → z/flags stable, in_ready=0 until out_ready=1; then single handoff, no duplicate out_valid.
- Reset asserted mid-MUL (cycle 8 of CALC) → all outputs 0 immediately, no out_valid afterwards, in_ready=1 after release; opcode 11111 then gives z=0, flag_err=1, flag_z=1.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides; single-cycle logic/arith ops
// and iterative shift-add multiply / restoring divide over WIDTH cycles.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int OP_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_err
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_NOT  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SHL  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SHR  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_DIVU = OP_W'(11);
    localparam logic [OP_W-1:0] OP_REMU = OP_W'(12);

    localparam logic [SH_W-1:0] CNT_LAST = SH_W'(WIDTH - 1);
    localparam logic [SH_W-1:0] CNT_ONE  = SH_W'(1);

    logic [1:0]       state_reg;
    logic [SH_W-1:0]  cnt_reg;
    logic [OP_W-1:0]  op_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] z_reg;
    logic             fz_reg;
    logic             fc_reg;
    logic             fv_reg;
    logic             ferr_reg;

    logic             accept;
    logic [WIDTH-1:0] and_v;
    logic [WIDTH-1:0] or_v;
    logic [WIDTH-1:0] xor_v;
    logic [WIDTH-1:0] not_v;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [SH_W-1:0]  sh;

    logic [WIDTH-1:0] sc_z;
    logic             sc_c;
    logic             sc_v;
    logic             sc_err;
    logic             sc_multi;

    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH:0]   rem_shift;
    logic             div_ge;
    logic [WIDTH-1:0] rem_diff;
    logic [WIDTH-1:0] div_rem_next;
    logic [WIDTH-1:0] div_quo_next;
    logic [WIDTH-1:0] mc_z;

    assign in_ready = (state_reg == S_IDLE) || ((state_reg == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    assign out_valid = (state_reg == S_DONE);
    assign z         = z_reg;
    assign flag_z    = fz_reg;
    assign flag_c    = fc_reg;
    assign flag_v    = fv_reg;
    assign flag_err  = ferr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
            assign and_v[gi] = x[gi] & y[gi];
            assign or_v[gi]  = x[gi] | y[gi];
            assign xor_v[gi] = x[gi] ^ y[gi];
            assign not_v[gi] = ~x[gi];
        end
    endgenerate

    // Subtraction as x + ~y + 1 so the carry out doubles as the no-borrow flag.
    assign add_sum = {1'b0, x} + {1'b0, y};
    assign sub_sum = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
    assign sh      = y[SH_W-1:0];

    always_comb begin
        sc_z     = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        sc_err   = 1'b0;
        sc_multi = 1'b0;
        case (op)
            OP_ADD: begin
                sc_z = add_sum[WIDTH-1:0];
                sc_c = add_sum[WIDTH];
                sc_v = (x[WIDTH-1] == y[WIDTH-1]) && (add_sum[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                sc_z = sub_sum[WIDTH-1:0];
                sc_c = sub_sum[WIDTH];
                sc_v = (x[WIDTH-1] != y[WIDTH-1]) && (sub_sum[WIDTH-1] != x[WIDTH-1]);
            end
            OP_AND:  sc_z = and_v;
            OP_OR:   sc_z = or_v;
            OP_XOR:  sc_z = xor_v;
            OP_NOT:  sc_z = not_v;
            OP_SHL:  sc_z = x << sh;
            OP_SHR:  sc_z = x >> sh;
            OP_SRA:  sc_z = $unsigned($signed(x) >>> sh);
            OP_SLT:  sc_z = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_MUL:  sc_multi = 1'b1;
            OP_DIVU: begin
                if (y == '0) begin
                    sc_z   = '1;
                    sc_err = 1'b1;
                end else begin
                    sc_multi = 1'b1;
                end
            end
            OP_REMU: begin
                if (y == '0) begin
                    sc_z   = x;
                    sc_err = 1'b1;
                end else begin
                    sc_multi = 1'b1;
                end
            end
            default: sc_err = 1'b1;
        endcase
    end

    // a_reg holds the shifting multiplicand (MUL) or the dividend/quotient (DIV/REM);
    // acc_reg holds the partial product or partial remainder.
    assign mul_acc_next = acc_reg + (b_reg[0] ? a_reg : '0);
    assign rem_shift    = {acc_reg, a_reg[WIDTH-1]};
    assign div_ge       = rem_shift >= {1'b0, b_reg};
    assign rem_diff     = rem_shift[WIDTH-1:0] - b_reg;
    assign div_rem_next = div_ge ? rem_diff : rem_shift[WIDTH-1:0];
    assign div_quo_next = {a_reg[WIDTH-2:0], div_ge};

    always_comb begin
        mc_z = div_rem_next;
        if (op_reg == OP_MUL) begin
            mc_z = mul_acc_next;
        end else if (op_reg == OP_DIVU) begin
            mc_z = div_quo_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
            acc_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            z_reg     <= '0;
            fz_reg    <= 1'b0;
            fc_reg    <= 1'b0;
            fv_reg    <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (sc_multi) begin
                            state_reg <= S_CALC;
                            cnt_reg   <= '0;
                            op_reg    <= op;
                            acc_reg   <= '0;
                            a_reg     <= x;
                            b_reg     <= y;
                        end else begin
                            state_reg <= S_DONE;
                            z_reg     <= sc_z;
                            fz_reg    <= (sc_z == '0);
                            fc_reg    <= sc_c;
                            fv_reg    <= sc_v;
                            ferr_reg  <= sc_err;
                        end
                    end else if ((state_reg == S_DONE) && out_ready) begin
                        state_reg <= S_IDLE;
                    end
                end
                S_CALC: begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                    if (op_reg == OP_MUL) begin
                        acc_reg <= mul_acc_next;
                        a_reg   <= a_reg << 1;
                        b_reg   <= b_reg >> 1;
                    end else begin
                        acc_reg <= div_rem_next;
                        a_reg   <= div_quo_next;
                    end
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= S_DONE;
                        z_reg     <= mc_z;
                        fz_reg    <= (mc_z == '0);
                        fc_reg    <= 1'b0;
                        fv_reg    <= 1'b0;
                        ferr_reg  <= 1'b0;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed checks of alu_seq (WIDTH=16) against an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z;
    logic         flag_z;
    logic         flag_c;
    logic         flag_v;
    logic         flag_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .OP_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_err  (flag_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected result; elat = extra clock edges after the accept edge before out_valid.
    task automatic model(input int opc, input int unsigned xa, input int unsigned ya,
                         output int unsigned ez, output bit ec, output bit ev,
                         output bit eerr, output int elat);
        int sx;
        int sy;
        int r;
        int unsigned sh;
        sx = (xa >= 32768) ? int'(xa) - 65536 : int'(xa);
        sy = (ya >= 32768) ? int'(ya) - 65536 : int'(ya);
        sh = ya % 16;
        ez = 0; ec = 0; ev = 0; eerr = 0; elat = 0;
        case (opc)
            0: begin
                r  = sx + sy;
                ez = (xa + ya) % 65536;
                ec = (xa + ya) >= 65536;
                ev = (r > 32767) || (r < -32768);
            end
            1: begin
                r  = sx - sy;
                ez = (xa + 65536 - ya) % 65536;
                ec = (xa >= ya);
                ev = (r > 32767) || (r < -32768);
            end
            2: ez = xa & ya;
            3: ez = xa | ya;
            4: ez = xa ^ ya;
            5: ez = 65535 - xa;
            6: ez = (xa << sh) % 65536;
            7: ez = xa >> sh;
            8: begin
                r  = sx >>> sh;
                ez = int'(r) & 32'hFFFF;
            end
            9: ez = (sx < sy) ? 1 : 0;
            10: begin
                ez   = (xa * ya) & 32'hFFFF;
                elat = W;
            end
            11: begin
                if (ya == 0) begin ez = 65535; eerr = 1; end
                else begin ez = xa / ya; elat = W; end
            end
            12: begin
                if (ya == 0) begin ez = xa; eerr = 1; end
                else begin ez = xa % ya; elat = W; end
            end
            default: eerr = 1;
        endcase
    endtask

    task automatic run_op(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold);
        int unsigned ez;
        bit ec;
        bit ev;
        bit eerr;
        int elat;
        int cyc;
        model(int'(o), int'(a), int'(b), ez, ec, ev, eerr, elat);
        op = o; x = a; y = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        #1;
        chk("idle_ready", in_ready, 1);
        tick;
        in_valid = 1'b0;
        op = 5'($urandom);
        x  = 16'($urandom);
        y  = 16'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            chk("busy_ready", in_ready, 0);
            tick;
            cyc++;
        end
        chk("latency", cyc, elat);
        chk("z", z, ez);
        chk("flag_z", flag_z, (ez == 0));
        chk("flag_c", flag_c, ec);
        chk("flag_v", flag_v, ev);
        chk("flag_err", flag_err, eerr);
        for (int h = 0; h < hold; h++) begin
            chk("hold_ready", in_ready, 0);
            tick;
            chk("hold_valid", out_valid, 1);
            chk("hold_z", z, ez);
            chk("hold_err", flag_err, eerr);
        end
        out_ready = 1'b1;
        #1;
        chk("handoff_ready", in_ready, 1);
        tick;
        chk("after_handoff_valid", out_valid, 0);
        $display("op=%02h x=%04h y=%04h z=%04h c=%0d v=%0d err=%0d edges=%0d hold=%0d",
                 o, a, b, ez, ec, ev, eerr, cyc, hold);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nvalid;
        logic [4:0]   ro;
        logic [W-1:0] rb;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; x = '0; y = '0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_z", z, 0);
        chk("rst_err", flag_err, 0);
        chk("rst_fz", flag_z, 0);
        tick;
        tick;
        reset = 1'b0;
        #1;
        chk("rst_ready", in_ready, 1);

        run_op(5'h00, 16'h7FFF, 16'h0001, 0);
        run_op(5'h0A, 16'h0003, 16'h0005, 0);
        run_op(5'h0A, 16'h0100, 16'h0100, 0);
        run_op(5'h0B, 16'h0064, 16'h0007, 0);
        run_op(5'h0C, 16'h0064, 16'h0007, 0);
        run_op(5'h00, 16'h1234, 16'h4321, 5);

        // Back-to-back single-cycle ops with in_valid held high.
        op = 5'h01; x = 16'h0005; y = 16'h0005;
        in_valid = 1'b1; out_ready = 1'b1;
        tick;
        op = 5'h09; x = 16'hFFFF; y = 16'h0001;
        #1;
        chk("b2b_sub_valid", out_valid, 1);
        chk("b2b_sub_z", z, 16'h0000);
        chk("b2b_sub_fz", flag_z, 1);
        chk("b2b_sub_fc", flag_c, 1);
        chk("b2b_sub_ready", in_ready, 1);
        $display("op=01 x=0005 y=0005 back-to-back z=%04h", z);
        tick;
        in_valid = 1'b0;
        #1;
        chk("b2b_slt_valid", out_valid, 1);
        chk("b2b_slt_z", z, 16'h0001);
        chk("b2b_slt_fc", flag_c, 0);
        $display("op=09 x=ffff y=0001 back-to-back z=%04h", z);
        tick;
        chk("b2b_end_valid", out_valid, 0);

        // Divide by zero leaves non-zero outputs that the reset below must clear.
        run_op(5'h0B, 16'h1234, 16'h0000, 0);
        run_op(5'h0C, 16'h00AB, 16'h0000, 0);

        op = 5'h0A; x = 16'h0003; y = 16'h0005;
        in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (8) tick;
        reset = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_z", z, 0);
        chk("midrst_fz", flag_z, 0);
        chk("midrst_fc", flag_c, 0);
        chk("midrst_fv", flag_v, 0);
        chk("midrst_err", flag_err, 0);
        tick;
        tick;
        reset = 1'b0;
        #1;
        chk("midrst_ready", in_ready, 1);
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (out_valid) nvalid++;
        end
        chk("midrst_no_output", nvalid, 0);
        $display("reset during MUL: abandoned, valid_after=%0d", nvalid);
        run_op(5'h1F, 16'h5A5A, 16'hA5A5, 0);

        for (int i = 0; i < 80; i++) begin
            ro = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(13, 31))
                                             : 5'($urandom_range(0, 12));
            rb = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            run_op(ro, 16'($urandom), rb, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
